// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one single-beat write engine among NUM_REQ requesters,
// with credit-limited issue, in-order completion routing and hang/spurious detection.
module axi_wr_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                 req_done,
    output logic                               wr_req,
    output logic [AXI_ADDR_WIDTH-1:0]          wr_addr,
    output logic [AXI_DATA_WIDTH-1:0]          wr_data,
    input  logic                               wr_done,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               busy,
    output logic                               timeout_err,
    output logic                               spurious_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] RR_LAST  = IDX_W'(NUM_REQ - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

    logic [IDX_W-1:0]          rr_q, rr_d;
    logic [OUT_W-1:0]          out_q, out_d;
    logic                      wr_req_q;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [AXI_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [NUM_REQ-1:0]        req_done_q, done_vec;
    logic [PTR_W-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic                      timeout_q, timeout_d;
    logic                      spurious_q, spurious_d;

    // Tag queue: requester index of every issued-but-not-completed write, oldest at rptr.
    logic [IDX_W-1:0] tag_mem [MAX_OUTSTANDING];

    logic [IDX_W-1:0] winner, hi_idx, lo_idx, head_tag;
    logic             hi_found, any_valid, grant, accept, pop;

    // Descending scan leaves the lowest valid index at or above rr_q in hi_idx,
    // and the lowest valid index overall in lo_idx for the wrap-around case.
    always_comb begin
        hi_found  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        any_valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_valid = 1'b1;
                lo_idx    = IDX_W'(i);
                if (IDX_W'(i) >= rr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        winner = hi_found ? hi_idx : lo_idx;
    end

    assign grant    = any_valid && (out_q < MAX_OUT) && !timeout_q;
    assign accept   = |(req_valid & req_ready);
    assign pop      = wr_done && (out_q != '0);
    assign head_tag = tag_mem[rptr_q];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_ready[gi] = grant && (winner == IDX_W'(gi));
            assign done_vec[gi]  = pop && (head_tag == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        rr_d      = rr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        out_d     = out_q;
        tmo_d     = tmo_q;

        if (accept) begin
            rr_d   = (winner == RR_LAST) ? '0 : winner + 1'b1;
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (winner == IDX_W'(i)) begin
                    wr_addr_d = req_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                    wr_data_d = req_data[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                end
            end
        end
        if (pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
        end

        case ({accept, pop})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase

        // Counts cycles spent waiting on a completion; any completion restarts it.
        if (wr_done || (out_q == '0)) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
        end

        timeout_d  = timeout_q | (tmo_d == TMO_MAX);
        spurious_d = spurious_q | (wr_done && (out_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= '0;
            out_q      <= '0;
            wr_req_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            req_done_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            tmo_q      <= '0;
            timeout_q  <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            out_q      <= out_d;
            wr_req_q   <= accept;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            req_done_q <= done_vec;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            tmo_q      <= tmo_d;
            timeout_q  <= timeout_d;
            spurious_q <= spurious_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[wptr_q] <= winner;
        end
    end

    assign req_done     = req_done_q;
    assign wr_req       = wr_req_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign outstanding  = out_q;
    assign busy         = (out_q != '0) || wr_req_q;
    assign timeout_err  = timeout_q;
    assign spurious_err = spurious_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: hand-computed vector table, directed corner sequences and
// randomized traffic checked every cycle against a queue-based transaction model.
module tb_axi_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int MO = 8;
    localparam int TO = 16;
    localparam int OW = $clog2(MO) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_ready, req_done;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic              wr_req;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              wr_done;
    logic [OW-1:0]     outstanding;
    logic              busy, timeout_err, spurious_err;

    always #5 clk = ~clk;

    axi_wr_arbiter #(
        .NUM_REQ(NR), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW),
        .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_done(req_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
        .outstanding(outstanding), .busy(busy),
        .timeout_err(timeout_err), .spurious_err(spurious_err)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Transaction-level reference model.
    int            m_rr;
    int            m_tags[$];
    bit            m_wr_req;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [NR-1:0] m_done;
    int            m_tmo;
    bit            m_terr, m_serr;

    typedef struct {
        logic [NR-1:0] valid;
        logic          done;
        logic [NR-1:0] exp_ready;
        int            exp_out;
        logic [NR-1:0] exp_rdone;
        logic          exp_serr;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0;
        m_tags.delete();
        m_wr_req = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_done = '0;
        m_tmo = 0;
        m_terr = 1'b0;
        m_serr = 1'b0;
    endtask

    function automatic int model_winner();
        if (m_tags.size() >= MO || m_terr) return -1;
        for (int k = 0; k < NR; k++) begin
            if (req_valid[(m_rr + k) % NR]) return (m_rr + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        int sz;
        if (rst) begin
            model_reset();
            return;
        end
        w  = model_winner();
        sz = m_tags.size();
        m_done = '0;
        if (wr_done) begin
            if (sz > 0) begin
                m_done[m_tags[0]] = 1'b1;
                void'(m_tags.pop_front());
            end else begin
                m_serr = 1'b1;
            end
        end
        m_wr_req = (w >= 0);
        if (w >= 0) begin
            m_tags.push_back(w);
            m_rr   = (w + 1) % NR;
            m_addr = req_addr[w*AW +: AW];
            m_data = req_data[w*DW +: DW];
        end
        if (wr_done || sz == 0) m_tmo = 0;
        else if (m_tmo < TO) m_tmo++;
        if (m_tmo == TO) m_terr = 1'b1;
    endtask

    task automatic compare_all();
        int w;
        logic [NR-1:0] er;
        w  = model_winner();
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        check("req_ready",    64'(req_ready),    64'(er));
        check("wr_req",       64'(wr_req),       64'(m_wr_req));
        check("wr_addr",      64'(wr_addr),      64'(m_addr));
        check("wr_data",      64'(wr_data),      64'(m_data));
        check("req_done",     64'(req_done),     64'(m_done));
        check("outstanding",  64'(outstanding),  64'(m_tags.size()));
        check("busy",         64'(busy),         64'((m_tags.size() != 0) || m_wr_req));
        check("timeout_err",  64'(timeout_err),  64'(m_terr));
        check("spurious_err", 64'(spurious_err), 64'(m_serr));
    endtask

    task automatic drive(input logic [NR-1:0] v, input logic d);
        req_valid = v;
        wr_done   = d;
        #1;
        compare_all();
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        wr_done   = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_payload_fixed();
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = 16'h1000 + 16'(i * 16);
            req_data[i*DW +: DW] = 32'hA500_0000 + 32'(i);
        end
    endtask

    function automatic int first_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        int grants[$];
        int dones[$];
        int due[$];
        int n_acc;
        logic d;

        rst = 1'b1; req_valid = '0; wr_done = 1'b0;
        set_payload_fixed();

        // Hand-computed table: valid, wr_done, ready, outstanding, req_done, spurious_err.
        tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 0, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0101, 1'b0, 4'b0001, 0, 4'b0000, 1'b0};
        tbl[2]  = '{4'b0101, 1'b0, 4'b0100, 1, 4'b0000, 1'b0};
        tbl[3]  = '{4'b0101, 1'b0, 4'b0001, 2, 4'b0000, 1'b0};
        tbl[4]  = '{4'b1000, 1'b1, 4'b1000, 3, 4'b0000, 1'b0};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 3, 4'b0001, 1'b0};
        tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 2, 4'b0100, 1'b0};
        tbl[7]  = '{4'b0010, 1'b1, 4'b0010, 2, 4'b0000, 1'b0};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 2, 4'b0001, 1'b0};
        tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1, 4'b1000, 1'b0};
        tbl[10] = '{4'b0000, 1'b0, 4'b0000, 0, 4'b0010, 1'b0};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 0, 4'b0000, 1'b0};
        tbl[12] = '{4'b0000, 1'b0, 4'b0000, 0, 4'b0000, 1'b1};

        do_reset();
        for (int r = 0; r < 13; r++) begin
            drive(tbl[r].valid, tbl[r].done);
            check($sformatf("tbl%0d_ready", r), 64'(req_ready),    64'(tbl[r].exp_ready));
            check($sformatf("tbl%0d_out", r),   64'(outstanding),  64'(tbl[r].exp_out));
            check($sformatf("tbl%0d_rdone", r), 64'(req_done),     64'(tbl[r].exp_rdone));
            check($sformatf("tbl%0d_serr", r),  64'(spurious_err), 64'(tbl[r].exp_serr));
            $display("tbl row %0d: valid=%b done=%b ready=%b out=%0d req_done=%b",
                     r, tbl[r].valid, tbl[r].done, req_ready, outstanding, req_done);
            tick();
        end

        // Single requester, completion 5 cycles after issue.
        do_reset();
        req_addr[2*AW +: AW] = 16'h0040;
        req_data[2*DW +: DW] = 32'hDEADBEEF;
        drive(4'b0100, 1'b0);
        check("single_ready", 64'(req_ready), 64'(4'b0100));
        tick();
        drive(4'b0000, 1'b0);
        check("single_wr_req", 64'(wr_req), 64'd1);
        check("single_addr", 64'(wr_addr), 64'h0040);
        check("single_data", 64'(wr_data), 64'hDEADBEEF);
        check("single_out1", 64'(outstanding), 64'd1);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(4'b0000, 1'b0);
            check("single_pulse", 64'(wr_req), 64'd0);
            tick();
        end
        drive(4'b0000, 1'b1);
        tick();
        drive(4'b0000, 1'b0);
        check("single_done", 64'(req_done), 64'(4'b0100));
        check("single_out0", 64'(outstanding), 64'd0);
        $display("single: wr_addr=%h req_done=%b out=%0d", wr_addr, req_done, outstanding);
        tick();
        set_payload_fixed();

        // All requesters valid, engine completes 2 cycles after each wr_req.
        do_reset();
        grants.delete(); dones.delete(); due.delete();
        for (int k = 0; k < 22; k++) begin
            d = 1'b0;
            if (due.size() > 0 && due[0] <= cyc) begin
                d = 1'b1;
                void'(due.pop_front());
            end
            drive((k < 16) ? 4'b1111 : 4'b0000, d);
            if (first_idx(req_ready) >= 0) grants.push_back(first_idx(req_ready));
            if (first_idx(req_done) >= 0) dones.push_back(first_idx(req_done));
            if (wr_req) due.push_back(cyc + 2);
            tick();
        end
        check("rr_grant_count", 64'(grants.size()), 64'd16);
        check("rr_done_count", 64'(dones.size()), 64'd16);
        for (int k = 0; k < 16 && k < grants.size() && k < dones.size(); k++) begin
            check($sformatf("rr_grant%0d", k), 64'(grants[k]), 64'(k % 4));
            check($sformatf("rr_done%0d", k), 64'(dones[k]), 64'(k % 4));
        end
        $display("round robin: %0d grants, %0d completions", grants.size(), dones.size());

        // Credit limit with completions withheld.
        do_reset();
        n_acc = 0;
        for (int k = 0; k < 10; k++) begin
            drive(4'b1111, 1'b0);
            if (req_ready != 0) n_acc++;
            tick();
        end
        drive(4'b1111, 1'b0);
        check("limit_accepts", 64'(n_acc), 64'd8);
        check("limit_ready", 64'(req_ready), 64'd0);
        check("limit_out", 64'(outstanding), 64'd8);
        tick();
        drive(4'b1111, 1'b1);
        check("limit_ready_on_done", 64'(req_ready), 64'd0);
        tick();
        n_acc = 0;
        for (int k = 0; k < 3; k++) begin
            drive(4'b1111, 1'b0);
            if (req_ready != 0) n_acc++;
            tick();
        end
        check("limit_one_more", 64'(n_acc), 64'd1);
        check("limit_out_again", 64'(outstanding), 64'd8);
        $display("credit limit: extra accepts after one completion=%0d out=%0d", n_acc, outstanding);

        // Accept and completion in the same cycle at outstanding=3.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(4'b0111, 1'b0);
            tick();
        end
        drive(4'b1000, 1'b1);
        check("same_ready", 64'(req_ready), 64'(4'b1000));
        check("same_out_before", 64'(outstanding), 64'd3);
        tick();
        drive(4'b0000, 1'b0);
        check("same_out_after", 64'(outstanding), 64'd3);
        check("same_done_oldest", 64'(req_done), 64'(4'b0001));
        check("same_addr", 64'(wr_addr), 64'h1030);
        tick();
        dones.delete();
        for (int k = 0; k < 5; k++) begin
            drive(4'b0000, (k < 3) ? 1'b1 : 1'b0);
            if (first_idx(req_done) >= 0) dones.push_back(first_idx(req_done));
            tick();
        end
        check("same_drain_count", 64'(dones.size()), 64'd3);
        for (int k = 0; k < 3 && k < dones.size(); k++)
            check($sformatf("same_drain%0d", k), 64'(dones[k]), 64'(k + 1));
        check("same_out_end", 64'(outstanding), 64'd0);
        $display("same-cycle push/pop: drained %0d completions", dones.size());

        // Hung write: timeout, grants blocked, late completion still routed.
        do_reset();
        drive(4'b0010, 1'b0);
        tick();
        for (int k = 1; k <= 17; k++) begin
            drive(4'b0000, 1'b0);
            if (k == 15) check("tmo_not_yet", 64'(timeout_err), 64'd0);
            if (k == 17) check("tmo_set", 64'(timeout_err), 64'd1);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(4'b1111, 1'b0);
            check("tmo_no_grant", 64'(req_ready), 64'd0);
            tick();
        end
        drive(4'b0000, 1'b1);
        tick();
        drive(4'b0000, 1'b0);
        check("tmo_late_done", 64'(req_done), 64'(4'b0010));
        check("tmo_out0", 64'(outstanding), 64'd0);
        check("tmo_sticky", 64'(timeout_err), 64'd1);
        $display("timeout: timeout_err=%b late req_done=%b", timeout_err, req_done);
        tick();

        // Spurious completion, then reset with writes in flight.
        do_reset();
        drive(4'b0000, 1'b1);
        tick();
        drive(4'b0000, 1'b0);
        check("spur_set", 64'(spurious_err), 64'd1);
        check("spur_no_done", 64'(req_done), 64'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(4'b0111, 1'b0);
            tick();
        end
        drive(4'b0000, 1'b0);
        check("rstmid_out3", 64'(outstanding), 64'd3);
        do_reset();
        drive(4'b0000, 1'b0);
        check("rstmid_zero", 64'({req_ready, req_done, wr_req, wr_addr, wr_data, outstanding,
                                   busy, timeout_err, spurious_err}), 64'd0);
        tick();
        drive(4'b0000, 1'b1);
        tick();
        drive(4'b0000, 1'b0);
        check("rstmid_spur_again", 64'(spurious_err), 64'd1);
        check("rstmid_no_done", 64'(req_done), 64'd0);
        $display("reset mid-op: spurious_err=%b out=%0d", spurious_err, outstanding);
        tick();

        // Randomized traffic against the model.
        do_reset();
        due.delete();
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NR; i++) begin
                req_addr[i*AW +: AW] = AW'($urandom);
                req_data[i*DW +: DW] = $urandom;
            end
            d = 1'b0;
            if ((k % 200) >= 10 && due.size() > 0 && due[0] <= cyc) begin
                d = 1'b1;
                void'(due.pop_front());
            end
            drive(($urandom_range(0, 3) == 0) ? 4'b0000 : NR'($urandom), d);
            if (wr_req) begin
                int t;
                t = cyc + $urandom_range(1, 5);
                if (due.size() > 0 && t <= due[$]) t = due[$] + 1;
                due.push_back(t);
            end
            tick();
        end
        $display("random: 3000 cycles done, out=%0d", outstanding);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
- Shares one single-beat AXI write engine among NUM_REQ independent requesters.
- The engine interface is a request pulse with address and data, plus a completion pulse `done` that arrives in order.
- The block does round-robin arbitration, issues at most one write per cycle, and enforces a credit limit on outstanding writes.
- It routes each completion back to the requester that originated it, using an in-order tag queue, and flags hung or spurious completions.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- AXI_DATA_WIDTH, 32, write data width.
- AXI_ADDR_WIDTH, 16, write address width.
- MAX_OUTSTANDING, 8, maximum issued-but-not-completed writes; power of 2, ≤ 32 (the engine's request queue depth).
- TIMEOUT_CYCLES, 4096, cycles without a completion while writes are outstanding before `timeout_err` is raised.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_addr  in  NUM_REQ*AXI_ADDR_WIDTH  flattened addresses; requester i occupies bits [i*AW +: AW].
- req_data  in  NUM_REQ*AXI_DATA_WIDTH  flattened data; same packing as req_addr.
- req_done  out  NUM_REQ  one-cycle completion pulse to the originating requester.
- wr_req  out  1  one-cycle issue pulse to the write engine.
- wr_addr  out  AXI_ADDR_WIDTH  address for the issued write; held until the next issue.
- wr_data  out  AXI_DATA_WIDTH  data for the issued write; held until the next issue.
- wr_done  in  1  engine completion pulse; completions are in issue order.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current credit usage.
- busy  out  1  high when outstanding != 0 or wr_req is high.
- timeout_err  out  1  sticky; cleared only by rst.
- spurious_err  out  1  sticky; set by wr_done while outstanding==0.

Behaviour:
- Reset values:
  - req_ready=0, req_done=0, wr_req=0, wr_addr=0, wr_data=0.
  - outstanding=0, busy=0, timeout_err=0, spurious_err=0.
  - rr pointer=0, tag queue empty, timeout counter=0.
- Grant condition (combinational): at least one req_valid set, outstanding < MAX_OUTSTANDING, and timeout_err=0.
- Grant selection:
  - Winner is the first requester with req_valid set, searching upward from the rr pointer and wrapping modulo NUM_REQ.
  - req_ready[winner]=1 in the same cycle; the handshake completes when req_valid&req_ready.
- Issue latency: on accept in cycle N, the following happen in cycle N+1:
  - wr_req=1 for exactly one cycle.
  - wr_addr and wr_data take the winner's registered values.
  - The winner index is pushed to the tag queue.
  - The rr pointer becomes (winner+1) mod NUM_REQ.
- The rr pointer changes only on an accept.
- A requester held valid across cycles gets back-to-back accepts only when no other requester is valid.
- outstanding update:
  - Increments on accept (cycle N, registered at N+1).
  - Decrements on wr_done when outstanding > 0.
  - Accept and wr_done in the same cycle: net unchanged.
  - Never exceeds MAX_OUTSTANDING; at the limit all req_ready=0 until a wr_done arrives.
- Completion routing:
  - On wr_done with a non-empty tag queue, pop the head index and drive req_done[head]=1 in the next cycle (1-cycle latency).
  - A push and pop in the same cycle are both honoured.
  - The tag queue is a circular buffer of depth MAX_OUTSTANDING with wrapping read/write pointers; it cannot overflow because of the credit limit.
- Spurious completion: wr_done while the tag queue is empty sets spurious_err, produces no req_done, and leaves outstanding at 0.
- Timeout counter:
  - Clears on any wr_done or whenever outstanding==0.
  - Otherwise increments, saturating.
  - Reaching TIMEOUT_CYCLES sets timeout_err.
  - While timeout_err=1 no new grants are made; completions still route normally.
- Reset mid-operation:
  - All state returns to reset values; in-flight tags are discarded.
  - A wr_done arriving after reset sets spurious_err.

Test Plan:
- Single requester: req_valid[2]=1, addr 0x0040, data 0xDEADBEEF for one accept; the engine returns wr_done 5 cycles later. Required: wr_req pulse in the cycle after the accept, wr_addr=0x0040, req_done[2] one cycle after wr_done, outstanding goes 0→1→0.
- All four requesters valid continuously, wr_done returned 2 cycles after each wr_req. Required: grant order 0,1,2,3,0,… and a req_done sequence in the same order.
- MAX_OUTSTANDING=8 with wr_done withheld. Required: exactly 8 accepts, req_ready all 0 and outstanding=8; one wr_done then allows exactly one further accept.
- wr_done and a new accept in the same cycle with outstanding=3. Required: outstanding stays 3, the tag push and pop are both correct, and req_done goes to the oldest requester.
- One write issued and wr_done never returned, with TIMEOUT_CYCLES=16. Required: timeout_err=1 after 16 cycles and no further grants; a late wr_done still pulses the correct req_done.
- wr_done with nothing outstanding, then rst asserted while 3 writes are outstanding. Required: spurious_err=1 and no req_done; after reset all outputs are 0, and the next wr_done sets spurious_err again.
